game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Parametrised game-flow controller for the runner game. It replaces the single start latch with a full session state machine: IDLE, RUN, HIT and OVER. It also provides a debounced jump button, a variable-rate game tick, multiple lives, score and speed-level tracking. The game tick drives the player, enemy and score logic; the collision detector feeds `collide` back in.

Parameters:
LIVES, 3, lives per session (1..7)
DEBOUNCE_CYC, 16, cycles the synchronised button must be stable before the debounced value changes (>=2)
TICK_DIV, 1024, base clocks per game tick at level 0 (power of two, >= 1<<LEVELS)
LEVELS, 4, number of speed levels (level 0..LEVELS-1)
SCORE_PER_LEVEL, 100, score increment between level-ups
HIT_FREEZE, 64, clocks spent in HIT before resuming
SCORE_W, 14, score width

Ports:
clock  in  1  system clock
rst  in  1  asynchronous active-low reset
jump  in  1  raw pushbutton, active-low, asynchronous to clock
collide  in  1  collision flag, level-sensitive
state  out  2  00 IDLE, 01 RUN, 10 HIT, 11 OVER
game_tick  out  1  one-cycle pulse, RUN only
jump_pulse  out  1  one-cycle pulse per debounced press, in any state
lives  out  3  remaining lives
level  out  $clog2(LEVELS)  current speed level
score  out  SCORE_W  session score, saturating

Behaviour:
- Reset (rst low, async) values:
  - state=IDLE, lives=LIVES, level=0, score=0.
  - game_tick=0, jump_pulse=0.
  - Synchroniser flops=1, debounced value=1, all counters=0.
- Button path:
  - 2-flop synchroniser on jump.
  - Debounce counter clears whenever the synchronised value equals the debounced value; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYC-1, the debounced value takes the synchronised value and the counter clears.
  - jump_pulse = 1 for the single cycle after the debounced value falls 1->0. Release produces no pulse.
  - Latency from a clean jump falling edge to jump_pulse: 2+DEBOUNCE_CYC+1 cycles.
- Tick generator:
  - Period P = TICK_DIV >> level clocks.
  - Counter runs only in RUN. It clears on every entry to RUN and is held at 0 elsewhere.
  - game_tick asserts when the counter equals P-1; the counter then wraps to 0.
  - A level change takes effect from the next wrap.
- State machine:
  - IDLE: lives=LIVES, score=0, level=0. On jump_pulse -> RUN.
  - RUN, on a game_tick cycle with collide=0:
    - score+1, saturating at 2^SCORE_W-1.
    - If the new score is a nonzero multiple of SCORE_PER_LEVEL and level<LEVELS-1, level+1 in the same cycle.
  - RUN, armed and collide=1 (takes priority over a tick in the same cycle; no score change that cycle):
    - lives-1.
    - If lives was 1 -> OVER (lives=0); else -> HIT.
  - Arming: when RUN is entered from HIT, collide is ignored until it has been sampled 0 for at least one cycle. When RUN is entered from IDLE, the block is armed immediately.
  - HIT: freeze counter counts HIT_FREEZE clocks; no ticks; collide ignored; then -> RUN.
  - OVER: score, level and lives hold. On jump_pulse -> IDLE, and IDLE values load on that transition.
  - jump_pulse in RUN/HIT is still output (player jump) and causes no state change.
- Reset mid-operation: immediate return to reset values regardless of state. A press in progress is discarded.
- All outputs registered; no combinational input-to-output path.

Test Plan:
- Reset then jump held low 40 cycles (DEBOUNCE_CYC=16) -> exactly one jump_pulse, at cycle 19 after the falling edge; state 00->01 the next cycle; no pulse on release.
- Jump bouncing (toggles every 5 cycles for 60 cycles, then stable low) -> single jump_pulse, 19 cycles after the final stable edge.
- RUN, TICK_DIV=1024, collide=0 -> ticks every 1024 clocks:
  - Score 99->100 sets level=1, after which ticks come every 512 clocks.
  - Level saturates at 3 (128-clock period) after score 300.
- Collide held high 200 cycles in RUN with LIVES=3 -> lives=2, state=10 for 64 clocks, then 01.
  - No further decrement while collide stays high.
  - After collide goes low then high again -> lives=1.
- Third hit -> state=11, lives=0, score frozen; jump_pulse -> state=00, score=0, lives=3, level=0.
- Collide and game_tick in the same cycle -> score unchanged, lives-1.
- rst low mid-HIT -> all outputs take reset values asynchronously.
- SCORE_W=4 -> score saturates at 15.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - runner game session FSM with debounced jump, variable-rate tick, lives, score and level
module game_flow_ctrl #(
    parameter int LIVES           = 3,
    parameter int DEBOUNCE_CYC    = 16,
    parameter int TICK_DIV        = 1024,
    parameter int LEVELS          = 4,
    parameter int SCORE_PER_LEVEL = 100,
    parameter int HIT_FREEZE      = 64,
    parameter int SCORE_W         = 14
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        jump,
    input  logic                        collide,
    output logic [1:0]                  state,
    output logic                        game_tick,
    output logic                        jump_pulse,
    output logic [2:0]                  lives,
    output logic [$clog2(LEVELS)-1:0]   level,
    output logic [SCORE_W-1:0]          score
);

    localparam int LVL_W  = $clog2(LEVELS);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int FRZ_W  = $clog2(HIT_FREEZE + 1);
    localparam int SPL_W  = $clog2(SCORE_PER_LEVEL + 1);

    localparam logic [TICK_W:0]  DIV       = (TICK_W + 1)'(TICK_DIV);
    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(LEVELS - 1);
    localparam logic [2:0]       LIVES_INI = 3'(LIVES);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HIT  = 2'b10,
        S_OVER = 2'b11
    } state_t;

    state_t            st;
    logic              sync1, sync2, deb, deb_d;
    logic [DB_W-1:0]   db_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [FRZ_W-1:0]  frz_cnt;
    logic [SPL_W-1:0]  lvl_cnt;
    logic              armed;

    logic [TICK_W:0]   period;
    logic              tick_due;
    logic              score_full;
    logic              lvl_wrap;

    assign state = st;

    // Period shrinks with level; compared against the running count so a level
    // change only matters once the counter has wrapped.
    assign period     = DIV >> level;
    assign tick_due   = ({1'b0, tick_cnt} == (period - 1'b1));
    assign score_full = (score == {SCORE_W{1'b1}});
    assign lvl_wrap   = (lvl_cnt == SPL_W'(SCORE_PER_LEVEL - 1));

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            deb        <= 1'b1;
            deb_d      <= 1'b1;
            db_cnt     <= '0;
            jump_pulse <= 1'b0;
        end else begin
            sync1      <= jump;
            sync2      <= sync1;
            deb_d      <= deb;
            jump_pulse <= deb_d & ~deb;
            if (sync2 == deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                deb    <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            st        <= S_IDLE;
            lives     <= LIVES_INI;
            level     <= '0;
            score     <= '0;
            game_tick <= 1'b0;
            tick_cnt  <= '0;
            frz_cnt   <= '0;
            lvl_cnt   <= '0;
            armed     <= 1'b0;
        end else begin
            game_tick <= 1'b0;
            case (st)
                S_IDLE: begin
                    lives    <= LIVES_INI;
                    score    <= '0;
                    level    <= '0;
                    lvl_cnt  <= '0;
                    tick_cnt <= '0;
                    if (jump_pulse) begin
                        st    <= S_RUN;
                        armed <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (armed && collide) begin
                        tick_cnt <= '0;
                        frz_cnt  <= '0;
                        lives    <= lives - 3'd1;
                        st       <= (lives == 3'd1) ? S_OVER : S_HIT;
                    end else begin
                        // A collision still asserted from the last hit must drop once before it counts again.
                        if (!collide) begin
                            armed <= 1'b1;
                        end
                        if (tick_due) begin
                            tick_cnt  <= '0;
                            game_tick <= 1'b1;
                            if (!collide && !score_full) begin
                                score <= score + 1'b1;
                                if (lvl_wrap) begin
                                    lvl_cnt <= '0;
                                    if (level != LVL_MAX) begin
                                        level <= level + 1'b1;
                                    end
                                end else begin
                                    lvl_cnt <= lvl_cnt + 1'b1;
                                end
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_HIT: begin
                    if (frz_cnt == FRZ_W'(HIT_FREEZE - 1)) begin
                        st      <= S_RUN;
                        armed   <= 1'b0;
                        frz_cnt <= '0;
                    end else begin
                        frz_cnt <= frz_cnt + 1'b1;
                    end
                end
                S_OVER: begin
                    if (jump_pulse) begin
                        st      <= S_IDLE;
                        lives   <= LIVES_INI;
                        score   <= '0;
                        level   <= '0;
                        lvl_cnt <= '0;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed bench for game_flow_ctrl with a cycle model and literal checks
module tb_game_flow_ctrl;

    localparam int LIVES = 3;
    localparam int DEB   = 16;
    localparam int TDIV  = 16;
    localparam int LEV   = 4;
    localparam int SPL   = 4;
    localparam int HF    = 64;
    localparam int SW    = 4;
    localparam int SMAX  = (1 << SW) - 1;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       jump = 1'b1;
    logic       collide = 1'b0;
    logic [1:0] state;
    logic       game_tick;
    logic       jump_pulse;
    logic [2:0] lives;
    logic [1:0] level;
    logic [3:0] score;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    // Behavioural model state: 0 idle, 1 run, 2 hit, 3 over
    int m_state, m_lives, m_level, m_score, m_age, m_frz, m_mis;
    bit m_armed, m_tick, m_jp, m_s1, m_s2, m_deb, m_deb_prev;

    game_flow_ctrl #(
        .LIVES(LIVES), .DEBOUNCE_CYC(DEB), .TICK_DIV(TDIV), .LEVELS(LEV),
        .SCORE_PER_LEVEL(SPL), .HIT_FREEZE(HF), .SCORE_W(SW)
    ) dut (
        .clock(clock), .rst(rst), .jump(jump), .collide(collide),
        .state(state), .game_tick(game_tick), .jump_pulse(jump_pulse),
        .lives(lives), .level(level), .score(score)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = LIVES; m_level = 0; m_score = 0;
        m_age = 0; m_frz = 0; m_mis = 0; m_armed = 0; m_tick = 0; m_jp = 0;
        m_s1 = 1; m_s2 = 1; m_deb = 1; m_deb_prev = 1;
    endtask

    task automatic model_step();
        bit n_deb;
        bit tick;
        int per;
        n_deb = m_deb;
        if (m_s2 == m_deb) m_mis = 0;
        else begin
            m_mis++;
            if (m_mis == DEB) begin
                n_deb = m_s2;
                m_mis = 0;
            end
        end
        tick = 0;
        case (m_state)
            0: if (m_jp) begin m_state = 1; m_armed = 1; m_age = 0; end
            1: begin
                per = TDIV / (1 << m_level);
                if (m_armed && collide) begin
                    m_lives--;
                    m_state = (m_lives == 0) ? 3 : 2;
                    m_frz = 0;
                    m_age = 0;
                end else begin
                    if (!collide) m_armed = 1;
                    if (m_age == per - 1) begin
                        tick = 1;
                        m_age = 0;
                        if (!collide && m_score < SMAX) begin
                            m_score++;
                            if (m_score % SPL == 0 && m_level < LEV - 1) m_level++;
                        end
                    end else m_age++;
                end
            end
            2: begin
                m_frz++;
                if (m_frz == HF) begin m_state = 1; m_armed = 0; m_age = 0; end
            end
            default: if (m_jp) begin m_state = 0; m_lives = LIVES; m_score = 0; m_level = 0; end
        endcase
        m_tick = tick;
        m_jp = m_deb_prev & ~m_deb;
        m_deb_prev = m_deb;
        m_deb = n_deb;
        m_s2 = m_s1;
        m_s1 = jump;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge rst);
        model_reset();
    end

    initial forever begin
        @(negedge clock);
        if (rst) begin
            check("m_state", int'(state), m_state);
            check("m_lives", int'(lives), m_lives);
            check("m_level", int'(level), m_level);
            check("m_score", int'(score), m_score);
            check("m_tick", int'(game_tick), int'(m_tick));
            check("m_jump_pulse", int'(jump_pulse), int'(m_jp));
            if (jump_pulse) pulse_cnt++;
        end
    end

    task automatic wait_pulse(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clock);
            if (jump_pulse) begin n = i; break; end
        end
    endtask

    task automatic wait_tick(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clock);
            if (game_tick) begin n = i; break; end
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check("rst_state", int'(state), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_level", int'(level), 0);
        check("rst_score", int'(score), 0);
        check("rst_tick", int'(game_tick), 0);
        check("rst_pulse", int'(jump_pulse), 0);
        rst = 1'b1;
        repeat (3) @(negedge clock);

        jump = 1'b0;
        wait_pulse(40, n);
        check("press_latency", n, 19);
        check("pulse_state_idle", int'(state), 0);
        @(negedge clock);
        check("enter_run", int'(state), 1);

        wait_tick(100, n);
        check("first_tick_gap", n, 16);
        check("score_1", int'(score), 1);
        wait_tick(100, n);
        check("tick_gap_l0", n, 16);
        for (int i = 0; i < 10 && score < 4; i++) wait_tick(100, n);
        check("level_1_at_4", int'(level), 1);
        wait_tick(100, n);
        check("tick_gap_l1", n, 8);
        for (int i = 0; i < 20 && score < 12; i++) wait_tick(100, n);
        check("level_3_at_12", int'(level), 3);
        wait_tick(100, n);
        check("tick_gap_l3", n, 2);
        repeat (20) @(negedge clock);
        check("score_sat", int'(score), 15);
        check("level_sat", int'(level), 3);

        jump = 1'b1;
        repeat (40) @(negedge clock);
        check("one_pulse_no_release", pulse_cnt, 1);

        for (int i = 0; i < 12; i++) begin
            jump = ~jump;
            repeat (5) @(negedge clock);
        end
        jump = 1'b0;
        wait_pulse(60, n);
        check("bounce_latency", n, 19);
        repeat (5) @(negedge clock);
        jump = 1'b1;
        repeat (30) @(negedge clock);
        check("bounce_single_pulse", pulse_cnt, 2);

        collide = 1'b1;
        @(negedge clock);
        check("hit1_lives", int'(lives), 2);
        check("hit1_state", int'(state), 2);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (state != 2'b10) break;
            n++;
        end
        check("hit_freeze_len", n, 64);
        repeat (130) @(negedge clock);
        check("held_no_decrement", int'(lives), 2);
        check("held_state_run", int'(state), 1);
        collide = 1'b0;
        repeat (2) @(negedge clock);
        collide = 1'b1;
        @(negedge clock);
        check("hit2_lives", int'(lives), 1);
        check("hit2_state", int'(state), 2);
        collide = 1'b0;
        repeat (70) @(negedge clock);
        check("back_to_run", int'(state), 1);
        collide = 1'b1;
        @(negedge clock);
        check("over_state", int'(state), 3);
        check("over_lives", int'(lives), 0);
        collide = 1'b0;
        repeat (10) @(negedge clock);
        check("over_score_frozen", int'(score), 15);
        check("over_hold", int'(state), 3);

        jump = 1'b0;
        wait_pulse(40, n);
        check("over_press_latency", n, 19);
        @(negedge clock);
        check("idle_state", int'(state), 0);
        check("idle_score", int'(score), 0);
        check("idle_lives", int'(lives), 3);
        check("idle_level", int'(level), 0);
        jump = 1'b1;
        repeat (30) @(negedge clock);
        jump = 1'b0;
        wait_pulse(40, n);
        @(negedge clock);
        check("rerun_state", int'(state), 1);
        jump = 1'b1;

        wait_tick(40, n);
        check("rerun_tick_gap", n, 16);
        repeat (15) @(negedge clock);
        collide = 1'b1;
        @(negedge clock);
        check("coinc_score", int'(score), 1);
        check("coinc_lives", int'(lives), 2);
        check("coinc_state", int'(state), 2);
        collide = 1'b0;

        repeat (5) @(negedge clock);
        #2 rst = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_lives", int'(lives), 3);
        check("arst_level", int'(level), 0);
        check("arst_score", int'(score), 0);
        check("arst_tick", int'(game_tick), 0);
        check("arst_pulse", int'(jump_pulse), 0);
        @(negedge clock);
        rst = 1'b1;
        repeat (5) @(negedge clock);
        check("post_rst_idle", int'(state), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
